// File: rtl/inst_loader.sv
// inst_loader: fills inst_memory from a little-endian byte stream and holds the
// core stalled until the program image has been written.
//
// Stream: count[7:0], count[15:8], then count 32-bit words sent LSB first.
// With INST_LOADER_CHECKSUM_EN defined, one trailing byte follows the last word.
// That byte is the XOR of every earlier byte, including both count bytes.
// On a checksum mismatch the loader parks in ERR and keeps the core held.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_valid      byte_data carries a stream byte
//   byte_data[7:0]  stream byte
//   byte_ready      loader takes a byte this cycle (transfer = valid & ready)
//   mem_we          one-cycle inst_memory write strobe
//   mem_addr[31:0]  byte address of the word being written
//   mem_wdata[31:0] word being written
//   cpu_hold        1 = core stalled
//   done            image loaded (sticky until rst)
//   error           bad header / checksum (sticky until rst)
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CHK, FIN, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, FIN, DONE, ERR} state_t;
`endif

    state_t             state, state_nxt;
    logic               armed;      // keeps byte_ready low for the first cycle out of reset
    logic [7:0]         cnt_lo;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   idx;
    logic [1:0]         lane;
    logic [23:0]        asm_word;   // lanes 0..2; lane 3 goes straight to mem_wdata
    logic [15:0]        hdr_raw;
    logic               xfer;
    logic               last_word;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    assign xfer      = byte_valid & byte_ready;
    assign hdr_raw   = {byte_data, cnt_lo};
    assign last_word = (idx == count - CNT_W'(1));
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cpu_hold  = (state != DONE);

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            CNT_LO, CNT_HI, DATA: byte_ready = armed;
`ifdef INST_LOADER_CHECKSUM_EN
            CHK:                  byte_ready = armed;
`endif
            default:              byte_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= CNT_LO;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CNT_LO: if (xfer) state_nxt = CNT_HI;
            CNT_HI: if (xfer) begin
                if (hdr_raw == 16'd0)              state_nxt = FIN;
                else if (32'(hdr_raw) > MAX_WORDS) state_nxt = ERR;
                else                               state_nxt = DATA;
            end
            DATA: if (xfer && lane == 2'd3 && last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state_nxt = CHK;
`else
                state_nxt = FIN;
`endif
            end
`ifdef INST_LOADER_CHECKSUM_EN
            // running XOR including the checksum byte itself must be zero
            CHK: if (xfer) state_nxt = ((chk ^ byte_data) == 8'd0) ? FIN : ERR;
`endif
            FIN:     state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            cnt_lo    <= 8'd0;
            count     <= '0;
            idx       <= '0;
            lane      <= 2'd0;
            asm_word  <= 24'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            chk       <= 8'd0;
`endif
        end else begin
            armed  <= 1'b1;
            mem_we <= 1'b0;
            if (xfer) begin
`ifdef INST_LOADER_CHECKSUM_EN
                chk <= chk ^ byte_data;
`endif
                case (state)
                    CNT_LO: cnt_lo <= byte_data;
                    CNT_HI: count  <= CNT_W'(hdr_raw);
                    DATA: begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_word[7:0]   <= byte_data;
                            2'd1: asm_word[15:8]  <= byte_data;
                            2'd2: asm_word[23:16] <= byte_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {byte_data, asm_word};
                                mem_addr  <= BASE_ADDR + (32'(idx) << 2);
                                idx       <= idx + CNT_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
